// File: rtl/pkt_mem_loader.sv
// pkt_mem_loader
// Receive-side packet loader for the cpu24multi shared data RAM.
// Packs an incoming valid/ready byte stream three bytes at a time
// (big-endian) into 24-bit words. It writes WORDS_PER_PKT words starting at
// LOAD_BASE while the CPU is halted. It then pulses receive_done so the CPU
// can leave halt.
//
// The block owns the RAM array. Its single write port is arbitrated between
// the loader and the CPU external memory port.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   rx_data       incoming byte
//   rx_valid      rx_data is valid
//   rx_ready      a byte is accepted on an edge where rx_valid & rx_ready
//   cpu_halt      CPU halt status (level)
//   cpu_we        CPU write enable
//   cpu_addr      CPU word address
//   cpu_wdata     CPU write data
//   cpu_rdata     combinational RAM read at cpu_addr
//   receive_done  one-cycle pulse when the packet has been written
//   load_busy     loader owns the RAM write port
//   word_count    words written in the current packet
//   pkt_count     completed packets since reset (wraps)
//   cpu_conflict  sticky flag: CPU tried to write while load_busy
module pkt_mem_loader #(
  parameter int unsigned DATA_AW       = 14,
  parameter int unsigned WORDS_PER_PKT = 784,
  parameter int unsigned LOAD_BASE     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               cpu_halt,
  input  logic               cpu_we,
  input  logic [DATA_AW-1:0] cpu_addr,
  input  logic [23:0]        cpu_wdata,
  output logic [23:0]        cpu_rdata,
  output logic               receive_done,
  output logic               load_busy,
  output logic [DATA_AW:0]   word_count,
  output logic [15:0]        pkt_count,
  output logic               cpu_conflict
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_RUN
  } state_t;

  localparam logic [DATA_AW-1:0] BASE_A  = DATA_AW'(LOAD_BASE);
  localparam logic [DATA_AW:0]   LAST_WC = (DATA_AW+1)'(WORDS_PER_PKT - 1);

  state_t             state;
  logic [1:0]         byte_idx;
  logic [23:0]        word;
  logic [DATA_AW-1:0] load_addr;
  logic [23:0]        mem [0:(1<<DATA_AW)-1];

  // Address wraps naturally by truncation to DATA_AW bits.
  assign load_addr = BASE_A + word_count[DATA_AW-1:0];
  assign cpu_rdata = mem[cpu_addr];

  // Outputs are registered. Each transition loads the output values
  // that belong to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_WAIT;
      byte_idx     <= '0;
      word         <= '0;
      rx_ready     <= 1'b0;
      receive_done <= 1'b0;
      load_busy    <= 1'b0;
      word_count   <= '0;
      pkt_count    <= '0;
      cpu_conflict <= 1'b0;
    end else begin
      receive_done <= 1'b0;
      if (cpu_we && load_busy) cpu_conflict <= 1'b1;

      case (state)
        S_WAIT: begin
          if (cpu_halt) begin
            state      <= S_COLLECT;
            rx_ready   <= 1'b1;
            load_busy  <= 1'b1;
            word_count <= '0;
            byte_idx   <= '0;
          end
        end

        S_COLLECT: begin
          if (rx_valid && rx_ready) begin
            case (byte_idx)
              2'd0:    word[23:16] <= rx_data;
              2'd1:    word[15:8]  <= rx_data;
              default: word[7:0]   <= rx_data;
            endcase
            if (byte_idx == 2'd2) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_WRITE: begin
          word_count <= word_count + 1'b1;
          if (word_count == LAST_WC) begin
            state        <= S_DONE;
            receive_done <= 1'b1;
          end else begin
            state    <= S_COLLECT;
            rx_ready <= 1'b1;
          end
        end

        S_DONE: begin
          pkt_count <= pkt_count + 16'd1;
          load_busy <= 1'b0;
          state     <= S_RUN;
        end

        S_RUN: begin
          // A persistent halt parks here, so no back-to-back reload occurs.
          if (!cpu_halt) state <= S_WAIT;
        end

        default: begin
          state     <= S_WAIT;
          rx_ready  <= 1'b0;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

  // Single write port. The loader write takes priority. A CPU write is only
  // honoured when the loader does not own the port.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) begin
      mem[load_addr] <= word;
    end else if (cpu_we && !load_busy) begin
      mem[cpu_addr] <= cpu_wdata;
    end
  end

endmodule
